// File: rtl/cache_bus_master.sv
// rtl/cache_bus_master.sv - 4-line direct-mapped write-back cache driving the snoop/memory bus
module cache_bus_master #(
    parameter logic [1:0] ReadMiss  = 2'b01,
    parameter logic [1:0] WriteBack = 2'b10,
    parameter logic [1:0] Idle      = 2'b00,
    parameter int         MEM_WORDS = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [2:0] cpu_addr,
    input  logic [3:0] cpu_wdata,
    output logic [3:0] cpu_rdata,
    output logic       cpu_ready,
    output logic       cpu_hit,
    output logic       cpu_err,
    output logic [8:0] bus,
    input  logic [8:0] mem_q
);

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WB, S_RM, S_FILL, S_RESP
    } state_t;

    typedef enum logic [1:0] {
        L_I = 2'b00, L_S = 2'b01, L_M = 2'b10
    } line_state_t;

    state_t      state, next_state;
    line_state_t line_st   [4];
    logic        line_tag  [4];
    logic [3:0]  line_data [4];

    logic       req_we;
    logic [2:0] req_addr;
    logic [3:0] req_wdata;

    logic [1:0] idx;
    logic       tg;
    logic       is_hit, is_err, is_dirty;

    // Upper response bits carry no data; keep them visibly consumed.
    logic unused_mem_q;
    assign unused_mem_q = ^mem_q[8:4];

    assign idx      = req_addr[1:0];
    assign tg       = req_addr[2];
    assign is_err   = int'(req_addr) >= MEM_WORDS;
    assign is_hit   = (line_st[idx] != L_I) && (line_tag[idx] == tg);
    assign is_dirty = line_st[idx] == L_M;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (cpu_req) next_state = S_COMPARE;
            S_COMPARE: begin
                if (is_err || is_hit) next_state = S_RESP;
                else if (is_dirty)    next_state = S_WB;
                else                  next_state = S_RM;
            end
            S_WB:      next_state = S_RM;
            S_RM:      next_state = S_FILL;
            S_FILL:    next_state = S_RESP;
            S_RESP:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                line_st[i]   <= L_I;
                line_tag[i]  <= 1'b0;
                line_data[i] <= 4'h0;
            end
            req_we    <= 1'b0;
            req_addr  <= 3'b0;
            req_wdata <= 4'h0;
            cpu_rdata <= 4'h0;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_err   <= 1'b0;
            bus       <= {Idle, 7'b0};
        end else begin
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                    end
                end
                S_COMPARE: begin
                    if (is_err) begin
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= 4'h0;
                    end else if (is_hit) begin
                        cpu_ready <= 1'b1;
                        cpu_hit   <= 1'b1;
                        if (req_we) begin
                            line_data[idx] <= req_wdata;
                            line_st[idx]   <= L_M;
                            cpu_rdata      <= req_wdata;
                        end else begin
                            cpu_rdata <= line_data[idx];
                        end
                    end else if (is_dirty) begin
                        bus <= {WriteBack, line_tag[idx], idx, line_data[idx]};
                    end else begin
                        bus <= {ReadMiss, req_addr, 4'h0};
                    end
                end
                S_WB: bus <= {ReadMiss, req_addr, 4'h0};
                S_FILL: begin
                    // Write-allocate: the fetched word is replaced by the store data.
                    line_tag[idx] <= tg;
                    if (req_we) begin
                        line_data[idx] <= req_wdata;
                        line_st[idx]   <= L_M;
                        cpu_rdata      <= req_wdata;
                    end else begin
                        line_data[idx] <= mem_q[3:0];
                        line_st[idx]   <= L_S;
                        cpu_rdata      <= mem_q[3:0];
                    end
                    bus       <= {Idle, 7'b0};
                    cpu_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bus_master.sv
// tb/tb_cache_bus_master.sv - self-checking bench for cache_bus_master with a bus memory model
module tb_cache_bus_master;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req;
    logic       cpu_we;
    logic [2:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic [3:0] cpu_rdata;
    logic       cpu_ready;
    logic       cpu_hit;
    logic       cpu_err;
    logic [8:0] bus;
    logic [8:0] mem_q = 9'b0;

    cache_bus_master dut (
        .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_err(cpu_err),
        .bus(bus), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Memory responder; shares the reset, so it ignores the bus while reset is high.
    logic [3:0] mem [8] = '{4'h1, 4'h2, 4'h6, 4'h4, 4'h9, 4'hA, 4'hC, 4'h0};
    always @(posedge clock) begin
        if (!reset) begin
            if (bus[8:7] == 2'b10 && bus[6:4] < 3'd7) mem[bus[6:4]] <= bus[3:0];
            if (bus[8:7] == 2'b01) mem_q <= {5'b0, mem[bus[6:4]]};
        end
    end

    typedef struct {
        logic       chk_rdata;
        logic [3:0] rdata;
        logic       hit;
        logic       err;
    } exp_t;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [3:0] wdata;
        logic       chk_rdata;
        logic [3:0] rdata;
        logic       hit;
        logic       err;
        int         lat;
        int         nmsg;
    } vec_t;

    int total = 0;
    int bad   = 0;

    exp_t       sbq[$];
    logic [8:0] msg_log[$];
    logic [8:0] prev_bus = 9'b0;
    logic [8:0] busv [0:20];
    exp_t       mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Message log plus response scoreboard.
    always @(negedge clock) begin
        if (!reset && bus[8:7] != 2'b00 && bus != prev_bus) msg_log.push_back(bus);
        prev_bus <= bus;
        if (cpu_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.chk_rdata) check("rdata", {28'b0, cpu_rdata}, {28'b0, mon_e.rdata});
                check("hit", {31'b0, cpu_hit}, {31'b0, mon_e.hit});
                check("err", {31'b0, cpu_err}, {31'b0, mon_e.err});
                check("bus_idle_at_ready", {23'b0, bus}, 32'h0);
            end
        end
    end

    task automatic push_exp(input logic chk, input logic [3:0] rd, input logic h, input logic e);
        exp_t x;
        x.chk_rdata = chk; x.rdata = rd; x.hit = h; x.err = e;
        sbq.push_back(x);
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            busv[lat] = bus;
        end while (!cpu_ready && lat < 20);
    endtask

    task automatic do_req(input vec_t v, input string name);
        int lat;
        int n0;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        push_exp(v.chk_rdata, v.rdata, v.hit, v.err);
        n0 = msg_log.size();
        wait_ready(lat);
        cpu_req = 1'b0;
        check({name, " latency"}, lat, v.lat);
        check({name, " msgs"}, msg_log.size() - n0, v.nmsg);
    endtask

    vec_t tbl [13];

    initial begin
        int lat;
        int n0;
        vec_t v;

        tbl[0]  = '{1'b0, 3'd5, 4'h0, 1'b1, 4'hA, 1'b0, 1'b0, 4, 1};
        tbl[1]  = '{1'b0, 3'd5, 4'h0, 1'b1, 4'hA, 1'b1, 1'b0, 2, 0};
        tbl[2]  = '{1'b1, 3'd1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 4, 1};
        tbl[3]  = '{1'b0, 3'd5, 4'h0, 1'b1, 4'hA, 1'b0, 1'b0, 5, 2};
        tbl[4]  = '{1'b0, 3'd1, 4'h0, 1'b1, 4'h3, 1'b0, 1'b0, 4, 1};
        tbl[5]  = '{1'b0, 3'd7, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2, 0};
        tbl[6]  = '{1'b1, 3'd7, 4'h5, 1'b1, 4'h0, 1'b0, 1'b1, 2, 0};
        tbl[7]  = '{1'b1, 3'd0, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 4, 1};
        tbl[8]  = '{1'b0, 3'd0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b0, 2, 0};
        tbl[9]  = '{1'b0, 3'd6, 4'h0, 1'b1, 4'hC, 1'b0, 1'b0, 4, 1};
        tbl[10] = '{1'b1, 3'd6, 4'h7, 1'b0, 4'h0, 1'b1, 1'b0, 2, 0};
        tbl[11] = '{1'b0, 3'd2, 4'h0, 1'b1, 4'h6, 1'b0, 1'b0, 5, 2};
        tbl[12] = '{1'b0, 3'd6, 4'h0, 1'b1, 4'h7, 1'b0, 1'b0, 4, 1};

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 3'd0; cpu_wdata = 4'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset bus", {23'b0, bus}, 32'h0);
        check("reset ready/hit/err", {29'b0, cpu_ready, cpu_hit, cpu_err}, 32'h0);
        check("reset rdata", {28'b0, cpu_rdata}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_req(tbl[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                check("vec0 bus c2", {23'b0, busv[2]}, {23'b0, 2'b01, 3'd5, 4'h0});
                check("vec0 bus c3", {23'b0, busv[3]}, {23'b0, 2'b01, 3'd5, 4'h0});
                check("vec0 bus c4", {23'b0, busv[4]}, 32'h0);
            end
            if (i == 3) begin
                check("vec3 wb msg", {23'b0, msg_log[msg_log.size()-2]}, {23'b0, 2'b10, 3'd1, 4'h3});
                check("vec3 rm msg", {23'b0, msg_log[msg_log.size()-1]}, {23'b0, 2'b01, 3'd5, 4'h0});
                check("vec3 wb bus c2", {23'b0, busv[2]}, {23'b0, 2'b10, 3'd1, 4'h3});
                check("mem word1", {28'b0, mem[1]}, 32'h3);
            end
            if (i == 11) check("mem word6", {28'b0, mem[6]}, 32'h7);
        end

        // Dirty line 2, then reset in the write-back cycle of its eviction.
        v = '{1'b1, 3'd2, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4, 1};
        do_req(v, "w2");
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd6; cpu_wdata = 4'h0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("abort wb on bus", {23'b0, bus}, {23'b0, 2'b10, 3'd2, 4'hF});
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("abort bus", {23'b0, bus}, 32'h0);
        check("abort ready/hit/err", {29'b0, cpu_ready, cpu_hit, cpu_err}, 32'h0);
        check("abort rdata", {28'b0, cpu_rdata}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sbq.delete();
        check("mem word2 kept", {28'b0, mem[2]}, 32'h6);
        v = '{1'b0, 3'd2, 4'h0, 1'b1, 4'h6, 1'b0, 1'b0, 4, 1};
        do_req(v, "r2 after reset");

        // Fill line 0, then write-hit and read-hit back to back with cpu_req held.
        v = '{1'b1, 3'd0, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 4, 1};
        do_req(v, "w0 fill");
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd0; cpu_wdata = 4'h4;
        push_exp(1'b0, 4'h0, 1'b1, 1'b0);
        n0 = msg_log.size();
        wait_ready(lat);
        check("b2b write latency", lat, 2);
        cpu_we = 1'b0; cpu_wdata = 4'h0;
        push_exp(1'b1, 4'h4, 1'b1, 1'b0);
        wait_ready(lat);
        check("b2b read latency", lat, 3);
        cpu_req = 1'b0;
        check("b2b msgs", msg_log.size() - n0, 0);

        repeat (4) @(negedge clock);
        check("scoreboard drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cache_bus_master.md
Name: cache_bus_master

Overview:
- Processor-side cache controller; the initiator end of the 9-bit snoop/memory bus.
- The memory block responds to the messages this block drives: bus = {estado[1:0], tag[2:0], valor[3:0]}.
  - WriteBack: memory stores valor at word tag.
  - ReadMiss: memory returns word tag on its q output.
- This block is a 4-line direct-mapped, write-back, write-allocate cache.
- It serves one CPU request at a time and issues WriteBack/ReadMiss messages on misses.

Parameters:
- ReadMiss, 2'b01, estado code for a read-miss request; must equal the memory's ReadMiss.
- WriteBack, 2'b10, estado code for a write-back; must equal the memory's WriteBack.
- Idle, 2'b00, estado code driven when no message is active; must differ from ReadMiss and WriteBack.
- MEM_WORDS, 7, number of valid memory words; addresses >= MEM_WORDS are errors.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request; held high until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  3  word address.
- cpu_wdata  in  4  write data.
- cpu_rdata  out  4  read data; valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  qualifies cpu_ready: 1 = hit.
- cpu_err  out  1  qualifies cpu_ready: 1 = address out of range.
- bus  out  9  registered message {estado, tag, valor}.
- mem_q  in  9  memory response; only [3:0] is used.

Behaviour:
- Storage: 4 lines, each holding {state[1:0]: I/S/M, tag[0], data[3:0]}.
  - index = addr[1:0], tag = addr[2].
  - Victim address = {line tag, index}.
- Reset: all lines I; FSM = IDLE; bus = {Idle, 3'b0, 4'b0}; cpu_ready = cpu_hit = cpu_err = 0; cpu_rdata = 0.
  - Reset mid-transaction aborts immediately. Dirty data is discarded; no write-back is issued.
- All outputs are registered.
- States: IDLE, COMPARE, WB, RM, FILL, RESP.
- IDLE: when cpu_req = 1, latch we/addr/wdata and go to COMPARE. The latched copy is used for the whole transaction; cpu_req dropping mid-transaction does not abort it.
- COMPARE:
  - addr >= MEM_WORDS: RESP with err = 1, hit = 0, rdata = 0. No bus traffic; cache unchanged.
  - Hit (line state != I and tag matches):
    - Read: rdata = line data.
    - Write: line data = wdata, state = M.
    - Then RESP with hit = 1.
  - Miss, victim in M: bus <= {WriteBack, victim addr, victim data}; go to WB.
  - Miss, victim in I or S: bus <= {ReadMiss, addr, 4'b0}; go to RM.
- WB: one cycle. Then bus <= {ReadMiss, addr, 4'b0}; go to RM. The bus value changes, so the memory sees two distinct messages.
- RM: one wait cycle for the memory response to settle; go to FILL.
- FILL:
  - Sample mem_q[3:0] into the line and set the line tag.
  - Read: state = S, rdata = mem_q[3:0].
  - Write: data = wdata, state = M (the fetched value is overwritten).
  - bus <= {Idle, 3'b0, 4'b0}; go to RESP with hit = 0.
- RESP: cpu_ready = 1 for exactly one cycle; rdata/hit/err valid. Next state IDLE. cpu_ready, hit and err return to 0 on the following cycle.
  - A cpu_req still high in the cycle after RESP starts a new transaction.
- Latency, counted from the IDLE cycle that samples cpu_req (cycle 0); cpu_ready is high in:
  - hit or err: cycle 2;
  - clean miss: cycle 4;
  - dirty miss: cycle 5.
- Bus is at Idle in IDLE, COMPARE and RESP. There are never two consecutive identical non-Idle messages.
- S lines are evicted silently (no bus message).

Test Plan:
- Reset, then read addr 5 (memory word 5 = 4'hA) -> bus shows {ReadMiss, 3'd5, 0} in cycles 2–3; cpu_ready in cycle 4 with rdata = 4'hA, hit = 0; bus back to Idle.
- Read addr 5 again -> cpu_ready in cycle 2, hit = 1, rdata = 4'hA, no bus message.
- Write addr 1 = 4'h3 (clean miss, line 1 → M), then read addr 5 (index 1, dirty victim) -> bus {WriteBack, 3'd1, 4'h3} in cycle 2, then {ReadMiss, 3'd5, 0}; memory word 1 = 4'h3; ready in cycle 5 with rdata = 4'hA.
- Read addr 7 -> cpu_ready cycle 2 with err = 1, hit = 0, rdata = 0; bus stays Idle throughout.
- Write addr 2 = 4'hF, assert reset in the WB/RM cycle of a later dirty eviction -> all outputs return to reset values; a subsequent read of addr 2 misses and returns the memory's original word 2.
- Write-hit then read-hit on addr 0 back-to-back with cpu_req held high -> two ready pulses, rdata = written value, no bus traffic after the initial fill.
